// File: rtl/pulse_train_gen.sv
// pulse_train_gen: per-channel programmable pulse trains (optional restart-while-busy via PULSE_RETRIGGER_EN)
module pulse_train_gen #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  parameter int NUM_W    = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS*CNT_W-1:0] high_len,
  input  logic [CHANNELS*CNT_W-1:0] low_len,
  input  logic [CHANNELS*NUM_W-1:0] pulse_num,
  output logic [CHANNELS-1:0]       signal,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       done
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;

  // a phase lasts len cycles (zero counts as one), so the counter runs from len-1 down to 0
  function automatic logic [CNT_W-1:0] dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, hl_q, hl_d, ll_q, ll_d;
    logic [NUM_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] h_in, l_in;
    logic [NUM_W-1:0] n_in;
    logic             go;
    assign h_in = high_len[g*CNT_W +: CNT_W];
    assign l_in = low_len[g*CNT_W +: CNT_W];
    assign n_in = pulse_num[g*NUM_W +: NUM_W];
    assign go   = start[g] && (n_in != '0);
    // rem counts pulses left including the one in flight; the last HIGH exits straight to IDLE
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hl_d    = hl_q;
      ll_d    = ll_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      case (state_q)
        HIGH: begin
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          else if (rem_q == NUM_W'(1)) begin
            state_d = IDLE;
            rem_d   = '0;
            done_d  = 1'b1;
          end else begin
            state_d = LOW;
            rem_d   = rem_q - 1'b1;
            cnt_d   = dec(ll_q);
          end
        end
        LOW: begin
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          else begin
            state_d = HIGH;
            cnt_d   = dec(hl_q);
          end
        end
        IDLE: ;
        default: state_d = IDLE;
      endcase
`ifdef PULSE_RETRIGGER_EN
      if (start[g] && state_q != IDLE && !go) begin
        state_d = IDLE;
        cnt_d   = '0;
        rem_d   = '0;
        done_d  = 1'b0;
      end
      if (go) begin
        state_d = HIGH;
        cnt_d   = dec(h_in);
        hl_d    = h_in;
        ll_d    = l_in;
        rem_d   = n_in;
        done_d  = 1'b0;
      end
`else
      if (go && state_q == IDLE) begin
        state_d = HIGH;
        cnt_d   = dec(h_in);
        hl_d    = h_in;
        ll_d    = l_in;
        rem_d   = n_in;
      end
`endif
    end
    // channel state registers, cleared asynchronously
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        hl_q    <= '0;
        ll_q    <= '0;
        rem_q   <= '0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        hl_q    <= hl_d;
        ll_q    <= ll_d;
        rem_q   <= rem_d;
        done_q  <= done_d;
      end
    end
    assign signal[g] = (state_q == HIGH);
    assign busy[g]   = (state_q != IDLE);
    assign done[g]   = done_q;
  end
endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

- Multi-channel, synthesizable pulse-train generator.
- Each channel, on a start request, emits a programmable number of pulses with programmable high and low widths, counted in clock cycles.
- Per-channel busy and done status is provided.
- Sits beside the `clock` generator and replaces fixed-delay stimulus pulses with clock-accurate, reconfigurable trains for downstream timing-sensitive blocks.

## Interface
- `CHANNELS`, default 4: number of independent channels.
- `CNT_W`, default 8: width of high/low length fields.
- `NUM_W`, default 4: width of pulse-count field.
- `clock`  input  1: single clock; all state updates on posedge.
- `reset`  input  1: asynchronous, active-high; clears all channels immediately.
- `start`  input  CHANNELS: per-channel start request, sampled at posedge.
- `high_len`  input  CHANNELS*CNT_W: channel i field at [i*CNT_W +: CNT_W]; high width in cycles.
- `low_len`  input  CHANNELS*CNT_W: channel i low width in cycles, same packing.
- `pulse_num`  input  CHANNELS*NUM_W: channel i pulse count, packed at [i*NUM_W +: NUM_W].
- `signal`  output  CHANNELS: registered pulse outputs.
- `busy`  output  CHANNELS: channel running a train.
- `done`  output  CHANNELS: one-cycle completion strobe.

## Operation
- Channels are fully independent; each runs its own FSM with states IDLE, HIGH and LOW.
- Each FSM has its own phase counter (CNT_W bits) and remaining-pulse counter (NUM_W bits).

Reset value of all outputs:
- `signal` = 0, `busy` = 0, `done` = 0.
- FSM = IDLE, counters = 0.

Start:
- In IDLE with `start[i]`=1 and `pulse_num` field ≠ 0, the channel latches `high_len`, `low_len` and `pulse_num` and goes to HIGH.
- `pulse_num` = 0: start ignored; no busy, no done.
- Later changes to the inputs do not affect a running train.

Length rules:
- `high_len` = 0 or `low_len` = 0 is treated as 1.
- Lengths are unsigned, with maximum 2^CNT_W−1 cycles.

States:
- HIGH: `signal`=1 for H cycles, then:
  - if pulses remain, go to LOW;
  - otherwise go to IDLE with `done`=1 for one cycle.
- LOW: `signal`=0 for L cycles, then go to HIGH.
- No LOW phase follows the final pulse.

`busy` is 1 in HIGH and LOW, 0 in IDLE.

Start while busy:
- Ignored (base build).

Start back-to-back:
- A start in the cycle where `done`=1 is accepted, because the FSM is already IDLE.

Reset mid-train:
- Immediate return to reset values on all channels.
- No done is generated.

## Timing
- Start sampled at edge E0 → `signal`=1 and `busy`=1 after E0; latency is one edge.
- Pulse k (k = 0..N−1) is high from edge E0 + k*(H+L) for H cycles.
- The final falling edge is at E_T, where T = N*H + (N−1)*L.
  - At E_T: `signal`=0, `busy`=0, `done`=1.
  - At E_T+1: `done`=0.
- Total busy duration: exactly T cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset acts asynchronously on assertion. The first start is accepted at the first posedge after deassertion.

## Configuration
- Macro `PULSE_RETRIGGER_EN`. When defined, `start[i]` with a nonzero `pulse_num` while busy restarts the channel:
  - new config is latched;
  - the FSM goes to HIGH after that edge;
  - `signal`=1 and `busy` stays 1;
  - no `done` is generated for the aborted train.
- A start with zero `pulse_num` while busy aborts to IDLE, with `signal`=0 and no done.
- Undefined: starts while busy are ignored, as in Operation.

## Test plan
- Single train: reset, then ch0 start with H=4, L=4, N=3.
  - `signal` shows 4-high/4-low ×3, with no trailing low phase.
  - `busy` high for exactly 20 cycles; `done` is a single-cycle pulse at cycle 20.
- Zero handling: H=0, L=0, N=2 → pattern 1,0,1, busy 3 cycles.
  - Separately, N=0 → no activity on any output.
- Parallel channels: ch0 (H=5, N=1) and ch3 (H=15, L=15, N=2) started together.
  - Independent waveforms; ch0 `done` at cycle 5, ch3 `done` at cycle 45.
  - Channels 1 and 2 remain 0.
- Busy start: ch1 train H=20, L=20, N=3, with a start pulse at cycle 10.
  - Base build: no effect, done at cycle 100.
  - With `PULSE_RETRIGGER_EN`: restart from cycle 11, no done at 100.
- Reset mid-train: assert `reset` asynchronously between edges during a HIGH phase → `signal`/`busy`/`done` drop to 0 immediately.
  - After release, a new start (H=2, N=1) runs normally.
- Back-to-back: `start` held continuously with H=3, L=1, N=2.
  - Trains repeat with `done` coinciding with acceptance.
  - Next `signal` rise one edge after `done`.
